// File: rtl/h80cpu_biu.sv
// H80 CPU bus interface unit: one request at a time, ADDR/DATA bus phases,
// wait_n stall handling with a timeout that reports rsp_err.
module h80cpu_biu #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BUS_CMD_WIDTH-1:0]  req_cmd,
    input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic [BUS_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [BUS_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data_,
    input  logic                      wait_n
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             stall_q, stall_d;
    logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      bus_act;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stall_q <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (req_valid) begin
                    addr_d  = req_addr;
                    cmd_d   = req_cmd;
                    wdata_d = req_wdata;
                    stall_d = '0;
                    state_d = ADDR;
                end
            end
            ADDR, DATA: begin
                if (wait_n) begin
                    stall_d = '0;
                    if (state_q == DATA) begin
                        rdata_d = data_;
                        state_d = DONE;
                    end else begin
                        state_d = cmd_q[0] ? DATA : DONE;
                    end
                end else if (stall_q == TO_LAST) begin
                    // stalled too long: abort, leave read data untouched
                    stall_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    stall_d = stall_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_act   = (state_q == ADDR) || (state_q == DATA);
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_err   = (state_q == DONE) && err_q;
    assign rsp_rdata = rdata_q;
    assign ce_n      = ~bus_act;
    assign addr      = addr_q;
    assign cmd       = cmd_q;
    assign data_     = (bus_act && !cmd_q[0]) ? wdata_q : {BUS_DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_h80cpu_biu.sv
// Directed bench for h80cpu_biu with a word-wide memory responder on the
// bus; stalls are injected by ce_n-low cycle index.
module tb_h80cpu_biu;

    localparam logic [2:0] WR_W = 3'b000;
    localparam logic [2:0] RD_W = 3'b001;
    localparam logic [2:0] RD_B = 3'b011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_cmd = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        ce_n;
    logic [15:0] addr;
    logic [2:0]  cmd;
    wire  [15:0] bus;
    logic        wait_n = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:255];
    logic [15:0] rd_val;

    always #5 clk = ~clk;

    h80cpu_biu #(
        .BUS_ADDR_WIDTH(16),
        .BUS_CMD_WIDTH (3),
        .BUS_DATA_WIDTH(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd  (req_cmd),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .ce_n     (ce_n),
        .addr     (addr),
        .cmd      (cmd),
        .data_    (bus),
        .wait_n   (wait_n)
    );

    // Responder: little-endian words, byte reads zero-extended
    always_comb begin
        rd_val = mem[addr[8:1]];
        if (cmd[1])
            rd_val = addr[0] ? {8'h00, rd_val[15:8]} : {8'h00, rd_val[7:0]};
    end

    assign bus = (!ce_n && cmd[0]) ? rd_val : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !cmd[0] && wait_n)
            mem[addr[8:1]] <= bus;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One transaction; wait_n is low for ce_n-low cycles
    // k in [s0, s0+sl).
    task automatic xact(input logic [2:0] c, input logic [15:0] a,
                        input logic [15:0] wd, input int s0, input int sl,
                        output int ce_cnt, output logic [15:0] rd,
                        output logic er, output logic [15:0] wbus,
                        output logic got, output logic bad_err);
        ce_cnt = 0;
        rd = '0;
        er = 1'b0;
        wbus = '0;
        got = 1'b0;
        bad_err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = c;
        req_addr  = a;
        req_wdata = wd;
        wait_n    = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (!rsp_valid && rsp_err) bad_err = 1'b1;
            if (!ce_n) begin
                wait_n = !(ce_cnt >= s0 && ce_cnt < s0 + sl);
                if (!c[0]) wbus = bus;
                ce_cnt++;
            end else begin
                wait_n = 1'b1;
            end
            if (rsp_valid) begin
                got = 1'b1;
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
        end
        @(negedge clk);
        chk("after_done_ce_n", {31'd0, ce_n}, 32'd1);
        chk("after_done_ready", {31'd0, req_ready}, 32'd1);
    endtask

    int          n;
    logic [15:0] rd, wb;
    logic        er, got, bad;
    logic        saw;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        req_valid = 1'b1;
        req_cmd   = WR_W;
        req_addr  = 16'h0040;
        req_wdata = 16'h5555;
        repeat (3) @(negedge clk);
        chk("rst_ce_n", {31'd0, ce_n}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_ignored_req", {31'd0, ce_n}, 32'd1);
        chk("rst_mem_untouched", {16'd0, mem[32]}, 32'd0);

        xact(WR_W, 16'h0010, 16'hBEEF, 0, 0, n, rd, er, wb, got, bad);
        chk("wr_got", {31'd0, got}, 32'd1);
        chk("wr_ce_cycles", n, 32'd1);
        chk("wr_bus_data", {16'd0, wb}, 32'h0000BEEF);
        chk("wr_err", {31'd0, er}, 32'd0);
        chk("wr_mem8", {16'd0, mem[8]}, 32'h0000BEEF);

        xact(RD_W, 16'h0010, 16'h0000, 0, 0, n, rd, er, wb, got, bad);
        chk("rd_got", {31'd0, got}, 32'd1);
        chk("rd_ce_cycles", n, 32'd2);
        chk("rd_data", {16'd0, rd}, 32'h0000BEEF);
        chk("rd_err", {31'd0, er}, 32'd0);
        chk("rd_err_idle", {31'd0, bad}, 32'd0);

        xact(WR_W, 16'h0010, 16'h12AB, 0, 0, n, rd, er, wb, got, bad);
        chk("wr2_mem8", {16'd0, mem[8]}, 32'h000012AB);
        xact(RD_B, 16'h0011, 16'h0000, 0, 0, n, rd, er, wb, got, bad);
        chk("rdb_data", {16'd0, rd}, 32'h00000012);
        chk("rdb_ce_cycles", n, 32'd2);

        xact(RD_W, 16'h0010, 16'h0000, 1, 5, n, rd, er, wb, got, bad);
        chk("rdstall_ce_cycles", n, 32'd7);
        chk("rdstall_data", {16'd0, rd}, 32'h000012AB);
        chk("rdstall_err", {31'd0, er}, 32'd0);

        xact(RD_W, 16'h0020, 16'h0000, 0, 1000, n, rd, er, wb, got, bad);
        chk("to_got", {31'd0, got}, 32'd1);
        chk("to_ce_cycles", n, 32'd8);
        chk("to_err", {31'd0, er}, 32'd1);
        chk("to_rdata_kept", {16'd0, rd}, 32'h000012AB);
        chk("to_err_idle", {31'd0, bad}, 32'd0);

        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = RD_W;
        req_addr  = 16'h0010;
        wait_n    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_in_data", {31'd0, ce_n}, 32'd0);
        wait_n = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        wait_n = 1'b1;
        chk("rstmid_ce_n", {31'd0, ce_n}, 32'd1);
        chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstmid_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || !ce_n) saw = 1'b1;
        end
        chk("rstmid_quiet", {31'd0, saw}, 32'd0);

        xact(RD_W, 16'h0010, 16'h0000, 0, 0, n, rd, er, wb, got, bad);
        chk("post_rst_got", {31'd0, got}, 32'd1);
        chk("post_rst_data", {16'd0, rd}, 32'h000012AB);
        chk("post_rst_err", {31'd0, er}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
